ram_sdp: RTL
============

# ram_sdp

Parametrised simple dual-port RAM: one write port with byte enables, one read port with a valid strobe, and a sequential clear engine in place of per-bit flop reset. Width, depth, read latency and clear value are generics. Out-of-range addresses are flagged. This is the general-purpose storage block for buffers and register files across the design.

## Interface
- DATA_W, 8, data width in bits; must be a multiple of BYTE_W
- BYTE_W, 8, bits per write-enable lane; NUM_BYTES = DATA_W/BYTE_W
- DEPTH, 8, number of words; any value ≥ 2, not necessarily a power of 2
- ADDR_W, max(1, clog2(DEPTH)), address width
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output register for latency 2
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear sweep

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  request a clear sweep; sampled only in READY
- busy  out  1  high while the sweep runs
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_be  in  NUM_BYTES  per-lane write enable
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data; holds between reads
- rd_valid  out  1  one-cycle strobe per accepted read
- addr_err  out  1  one-cycle pulse when an accepted access has an address ≥ DEPTH

## Operation
- FSM states:
  - INIT: sweep counter cnt steps 0..DEPTH-1 and writes INIT_VAL to mem[cnt], one word per cycle.
  - READY: normal access.
- Reset values:
  - state = INIT, cnt = 0, busy = 1
  - rd_data = 0, rd_valid = 0, addr_err = 0
  - all pipeline stages invalid
  - The array has no reset.
- INIT → READY on the edge that writes word DEPTH-1. busy falls on that same edge.
- READY → INIT on an edge where clr = 1; cnt = 0 and busy rises. clr during INIT is ignored.
- In INIT, wr_en and rd_en are ignored: no write, no rd_valid, no addr_err.
- Write, in READY with wr_en = 1:
  - If wr_addr < DEPTH, each lane i with wr_be[i] = 1 takes wr_data lane i. Other lanes keep their value.
  - If wr_addr ≥ DEPTH, nothing is written and addr_err pulses.
  - wr_be = 0 is a legal no-op.
- Read, in READY with rd_en = 1:
  - If rd_addr < DEPTH, rd_data = mem[rd_addr] after the latency.
  - If rd_addr ≥ DEPTH, rd_data = 0, rd_valid still asserts, and addr_err pulses.
- Both accesses out of range in the same cycle: a single addr_err pulse.
- Read and write to the same address in the same cycle: rd_data returns the old word, unless RAM_BYPASS_EN is defined (see Configuration).
- Reads issued before a clr complete normally with pre-clear data.
- rst_n assertion mid-operation aborts everything immediately: in-flight reads are dropped and a new sweep starts after release.

## Timing
- Sweep: rst_n released before edge 0. Edges 0..DEPTH-1 write words 0..DEPTH-1. busy is low after edge DEPTH-1. The first access is accepted at edge DEPTH.
- OUT_REG = 0: a read accepted at edge N gives rd_data and rd_valid from edge N+1.
- OUT_REG = 1: the same read gives its result from edge N+2.
- Fully pipelined: one read and one write per cycle, no stalls.
- addr_err is asserted from edge N+1 for an access accepted at edge N, regardless of OUT_REG.
- A write at edge N is visible to a read accepted at edge N+1.

## Configuration
- RAM_BYPASS_EN defined: a same-cycle, same-address read returns the merged word. Lanes with wr_be = 1 take wr_data; other lanes take the old contents.
- RAM_BYPASS_EN undefined: a same-cycle, same-address read returns the old word. No forwarding logic is built.

## Structure
- Package ram_pkg holds:
  - state enum ram_state_t {ST_INIT, ST_READY}
  - function clog2_min1 for the ADDR_W default
- Sub-module ram_array holds the storage:
  - byte-enable write and registered read
  - no reset, so it maps to block RAM
- ram_sdp holds the FSM, sweep mux, range checks, bypass logic and OUT_REG stage.

## Test plan
- Reset release, DATA_W=16, DEPTH=8, INIT_VAL=16'hA5A5 → busy high for exactly 8 edges; then reads of addresses 0..7 all return A5A5.
- Write 16'h1234 to address 3 with wr_be=2'b01, then read address 3 → 16'hA534 with one rd_valid pulse; latency 1 for OUT_REG=0 and 2 for OUT_REG=1.
- DEPTH=6: write to address 7 and read address 6 → memory unchanged; addr_err pulses; the read returns rd_valid=1 with rd_data=0.
- Same-cycle write of 16'hBEEF (wr_be=2'b11) and read at address 2, holding 16'h0000 → returns 0000 without RAM_BYPASS_EN and BEEF with it.
- Back-to-back reads of addresses 0..7 on consecutive cycles, OUT_REG=1 → 8 consecutive rd_valid cycles with data in order.
- Pulse clr after writes, then reassert rst_n low mid-sweep → busy stays high; rd_valid is 0; after release, a full DEPTH-cycle sweep runs and all words read INIT_VAL.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple dual-port RAM.
// State encoding for the clear-sweep FSM and the address-width default.
package ram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } ram_state_t;

    // Address width for a given depth, never narrower than one bit.
    function automatic int clog2_min1(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Storage array for ram_sdp: byte-enable write port, registered read port.
// Callers must only present in-range addresses with we/re asserted.
module ram_array import ram_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int BYTE_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = clog2_min1(DEPTH),
    localparam int NUM_BYTES = DATA_W / BYTE_W
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [NUM_BYTES-1:0] wbe,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 re,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and its read register carry no reset so the tools can
    // map them onto block RAM; the owner clears contents with a sweep instead.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_sdp.sv
// Simple dual-port RAM with byte enables, range checking and a clear sweep.
// Optional macro RAM_BYPASS_EN forwards same-cycle writes to a colliding read.
module ram_sdp import ram_pkg::*; #(
    parameter int              DATA_W   = 8,
    parameter int              BYTE_W   = 8,
    parameter int              DEPTH    = 8,
    parameter int              ADDR_W   = clog2_min1(DEPTH),
    parameter int              OUT_REG  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    localparam int             NUM_BYTES = DATA_W / BYTE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    output logic                 busy,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [NUM_BYTES-1:0] wr_be,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic                 addr_err
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    ram_state_t        state, state_d;
    logic [ADDR_W-1:0] cnt, cnt_d;

    logic ready, wr_in, rd_in, wr_ok, rd_ok;

    assign ready = (state == ST_READY);
    assign busy  = ~ready;
    assign wr_in = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_ok = ready & wr_en & wr_in;
    assign rd_ok = ready & rd_en & rd_in;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            ST_INIT: begin
                if (cnt == LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // The sweep owns the write port while the FSM is in INIT.
    logic                 arr_we;
    logic [ADDR_W-1:0]    arr_waddr;
    logic [NUM_BYTES-1:0] arr_wbe;
    logic [DATA_W-1:0]    arr_wdata;
    logic [DATA_W-1:0]    arr_q;

    assign arr_we    = ready ? wr_ok   : 1'b1;
    assign arr_waddr = ready ? wr_addr : cnt;
    assign arr_wbe   = ready ? wr_be   : {NUM_BYTES{1'b1}};
    assign arr_wdata = ready ? wr_data : INIT_VAL;

    ram_array #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wbe   (arr_wbe),
        .wdata (arr_wdata),
        .re    (rd_ok),
        .raddr (rd_addr),
        .rdata (arr_q)
    );

    // First read stage: remembers how to interpret the array output.
    logic              s1_valid, keep_mem_q;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            keep_mem_q <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            s1_valid <= ready & rd_en;
            if (ready & rd_en) begin
                keep_mem_q <= rd_in;
            end
            addr_err <= ready & ((wr_en & ~wr_in) | (rd_en & ~rd_in));
        end
    end

`ifdef RAM_BYPASS_EN
    logic [NUM_BYTES-1:0] fwd_be_q;
    logic [DATA_W-1:0]    fwd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_be_q   <= '0;
            fwd_data_q <= '0;
        end else if (ready & rd_en) begin
            fwd_be_q   <= (rd_ok && wr_ok && (wr_addr == rd_addr)) ? wr_be : '0;
            fwd_data_q <= wr_data;
        end
    end

    always_comb begin
        s1_data = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (fwd_be_q[i]) begin
                s1_data[i*BYTE_W +: BYTE_W] = fwd_data_q[i*BYTE_W +: BYTE_W];
            end else if (keep_mem_q) begin
                s1_data[i*BYTE_W +: BYTE_W] = arr_q[i*BYTE_W +: BYTE_W];
            end
        end
    end
`else
    assign s1_data = keep_mem_q ? arr_q : '0;
`endif

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              s2_valid;
            logic [DATA_W-1:0] s2_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rd_valid = s2_valid;
            assign rd_data  = s2_data;
        end else begin : g_no_out_reg
            assign rd_valid = s1_valid;
            assign rd_data  = s1_data;
        end
    endgenerate

endmodule
